// File: rtl/tx_sched.sv
// tx_sched: serialises echo (pong) and ramp/DC sample readout jobs onto a byte-wide UART TX.
// Requests are latched as pending flags and served one job at a time (pong > ramp > dc).
// Build option: define TX_SCHED_CHECKSUM_EN to append an XOR checksum byte to every stream job.
//
// state | meaning
// IDLE  | no job; picks the highest-priority pending request once the transmitter is free
// SEND  | one-cycle tx_start with the staged byte
// GUARD | one cycle in which tx_busy is ignored while the transmitter picks up the byte
// WAIT  | hold until tx_busy=0, then choose the next step of the job
// FETCH | sample_rd pulse for the current sample address
// LO    | capture sample_data, stage its low byte
// HI    | stage the high byte of the captured sample
// CSUM  | stage the checksum byte (checksum build only)
module tx_sched #(
    parameter logic [7:0] RAMP_HDR = 8'h07,
    parameter logic [7:0] DC_HDR   = 8'h08
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pong_trig,
    input  logic [7:0]  pong_data,
    input  logic        ramp_req,
    input  logic        dc_req,
    input  logic [15:0] read_length,
    output logic        sample_rd,
    output logic [15:0] sample_addr,
    input  logic [15:0] sample_data,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_busy,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE, SEND, GUARD, WAIT, FETCH, LO, HI
`ifdef TX_SCHED_CHECKSUM_EN
        , CSUM
`endif
    } state_t;

    // Which byte of the job is in flight; WAIT uses it to pick the next step.
    typedef enum logic [2:0] {
        PH_PONG, PH_HDR, PH_LO, PH_HI
`ifdef TX_SCHED_CHECKSUM_EN
        , PH_CSUM
`endif
    } phase_t;

    state_t      state, state_n;
    phase_t      phase;
    logic        pong_p, ramp_p, dc_p;
    logic        serve_pong, serve_ramp, serve_dc;
    logic [7:0]  pong_byte;
    logic [7:0]  tx_byte;
    logic [7:0]  sample_hi;
    logic [15:0] remain;
    logic [15:0] addr;
`ifdef TX_SCHED_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    // State register; reset aborts any job in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    // Next-state decode, arbitration and strobes.
    always_comb begin
        state_n    = state;
        tx_start   = 1'b0;
        sample_rd  = 1'b0;
        done       = 1'b0;
        serve_pong = 1'b0;
        serve_ramp = 1'b0;
        serve_dc   = 1'b0;
        case (state)
            IDLE: begin
                if (!tx_busy) begin
                    if (pong_p) begin
                        serve_pong = 1'b1;
                        state_n    = SEND;
                    end else if (ramp_p) begin
                        serve_ramp = 1'b1;
                        state_n    = SEND;
                    end else if (dc_p) begin
                        serve_dc = 1'b1;
                        state_n  = SEND;
                    end
                end
            end
            SEND: begin
                // Never start a byte into a busy transmitter.
                if (!tx_busy) begin
                    tx_start = 1'b1;
                    state_n  = GUARD;
                end
            end
            GUARD: state_n = WAIT;
            WAIT: begin
                if (!tx_busy) begin
                    case (phase)
                        PH_LO: state_n = HI;
                        PH_HDR, PH_HI: begin
                            if (remain == 16'd0) begin
`ifdef TX_SCHED_CHECKSUM_EN
                                state_n = CSUM;
`else
                                state_n = IDLE;
                                done    = 1'b1;
`endif
                            end else begin
                                state_n = FETCH;
                            end
                        end
                        default: begin
                            state_n = IDLE;
                            done    = 1'b1;
                        end
                    endcase
                end
            end
            FETCH: begin
                sample_rd = 1'b1;
                state_n   = LO;
            end
            LO: state_n = SEND;
            HI: state_n = SEND;
`ifdef TX_SCHED_CHECKSUM_EN
            CSUM: state_n = SEND;
`endif
            default: state_n = IDLE;
        endcase
    end

    // Pending flags, job setup and byte staging.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pong_p    <= 1'b0;
            ramp_p    <= 1'b0;
            dc_p      <= 1'b0;
            pong_byte <= 8'h00;
            tx_byte   <= 8'h00;
            sample_hi <= 8'h00;
            remain    <= 16'd0;
            addr      <= 16'd0;
            phase     <= PH_PONG;
`ifdef TX_SCHED_CHECKSUM_EN
            csum      <= 8'h00;
`endif
        end else begin
            // A new request in the same cycle its flag is served stays pending.
            pong_p <= (pong_p & ~serve_pong) | pong_trig;
            ramp_p <= (ramp_p & ~serve_ramp) | ramp_req;
            dc_p   <= (dc_p & ~serve_dc) | dc_req;
            if (pong_trig) pong_byte <= pong_data;

            if (serve_pong) begin
                tx_byte <= pong_byte;
                phase   <= PH_PONG;
            end
            if (serve_ramp || serve_dc) begin
                tx_byte <= serve_ramp ? RAMP_HDR : DC_HDR;
                phase   <= PH_HDR;
                remain  <= read_length;
                addr    <= 16'd0;
`ifdef TX_SCHED_CHECKSUM_EN
                csum    <= 8'h00;
`endif
            end
            if (state == LO) begin
                tx_byte   <= sample_data[7:0];
                sample_hi <= sample_data[15:8];
                remain    <= remain - 16'd1;
                addr      <= addr + 16'd1;
                phase     <= PH_LO;
`ifdef TX_SCHED_CHECKSUM_EN
                csum      <= csum ^ sample_data[7:0];
`endif
            end
            if (state == HI) begin
                tx_byte <= sample_hi;
                phase   <= PH_HI;
`ifdef TX_SCHED_CHECKSUM_EN
                csum    <= csum ^ sample_hi;
`endif
            end
`ifdef TX_SCHED_CHECKSUM_EN
            if (state == CSUM) begin
                tx_byte <= csum;
                phase   <= PH_CSUM;
            end
`endif
        end
    end

    // Data outputs are zero whenever their strobe is low; busy falls with the final done.
    assign sample_addr = sample_rd ? addr : 16'd0;
    assign tx_data     = tx_start ? tx_byte : 8'h00;
    assign busy        = (state != IDLE) && !done;

endmodule

// File: doc/tx_sched.md
TX_SCHED -- requirements
Module: tx_sched

Interface
REQ-001 The module SHALL have parameter RAMP_HDR, default 8'h07, the header byte sent before a ramp readout.
REQ-002 The module SHALL have parameter DC_HDR, default 8'h08, the header byte sent before a DC readout.
REQ-003 The module SHALL have one clock and asynchronous active-low reset: clk  input  1  rising-edge clock; rst  input  1  asynchronous reset, active-low (0 = reset).
REQ-004 The module SHALL have these request ports: pong_trig  input  1  one-cycle echo request; pong_data  input  8  echo byte, sampled with pong_trig.
REQ-005 The module SHALL have these readout ports: ramp_req  input  1  one-cycle ramp readout request; dc_req  input  1  one-cycle DC readout request; read_length  input  16  sample count, sampled at stream start.
REQ-006 The module SHALL have these sample-buffer ports: sample_rd  output  1  read strobe; sample_addr  output  16  read address; sample_data  input  16  read data, valid one cycle after sample_rd.
REQ-007 The module SHALL have these UART TX ports: tx_start  output  1  one-cycle send strobe; tx_data  output  8  byte to send, valid with tx_start; tx_busy  input  1  transmitter busy.
REQ-008 The module SHALL have these status ports: busy  output  1  high in any non-IDLE state; done  output  1  one-cycle pulse at the end of each job.

Function
REQ-009 The module SHALL set pending flags pong_p, ramp_p and dc_p on the matching request pulse; pong_trig SHALL also capture pong_data, and a later pong_trig while pong_p is set SHALL overwrite the captured byte.
REQ-010 In IDLE with tx_busy=0, the module SHALL serve the highest-priority pending flag in the order pong > ramp > dc, and SHALL clear that flag on the cycle it leaves IDLE.
REQ-011 Requests arriving during a job SHALL be queued, never interleaved; a ramp_req/dc_req arriving while a job of the same type is active SHALL still set its flag and run afterwards.
REQ-012 The FSM SHALL have these states: IDLE, SEND, GUARD, WAIT, FETCH, LO, HI, and (with the Configuration macro defined) CSUM.
REQ-013 Byte send: SEND SHALL drive tx_start=1 for exactly one cycle with tx_data, then move to GUARD, which ignores tx_busy for one cycle, then to WAIT, which holds until tx_busy=0.
REQ-014 A pong job SHALL be a single byte (the captured byte), followed by done and a return to IDLE.
REQ-015 A stream job SHALL latch read_length into a 16-bit counter and send the header byte (RAMP_HDR or DC_HDR).
REQ-016 For each sample i = 0..N-1, the stream SHALL pulse sample_rd with sample_addr=i (FETCH), register sample_data on the next cycle, then send sample_data[7:0] (LO) followed by sample_data[15:8] (HI).
REQ-017 When read_length=0, the stream SHALL send the header only, then pulse done.
REQ-018 sample_addr SHALL be 16 bits and SHALL never wrap: read_length=16'hFFFF reads addresses 0..16'hFFFE.
REQ-019 A read_length change during a job SHALL NOT affect that job.
REQ-020 tx_start SHALL never assert while tx_busy=1.
REQ-021 done SHALL pulse on the cycle the final WAIT exits; busy SHALL drop on that same cycle.
REQ-022 When a request pulse coincides with done, the request SHALL be kept and served next.

Reset
REQ-023 While rst=0, the module SHALL hold state=IDLE, all pending flags=0, and tx_start, tx_data, sample_rd, sample_addr, busy and done all 0.
REQ-024 Reset asserted mid-job SHALL abort the job immediately, with no done pulse and no further tx_start.
REQ-025 Request pulses coincident with reset SHALL be discarded.

Configuration
REQ-026 With macro TX_SCHED_CHECKSUM_EN defined, each stream job SHALL append one byte (state CSUM) equal to the XOR of all LO/HI bytes of that job, header excluded (8'h00 when read_length=0); pong jobs SHALL be unchanged.
REQ-027 With TX_SCHED_CHECKSUM_EN undefined, no checksum byte and no CSUM state SHALL exist.

Verification
REQ-028 The bench SHALL cover: pong_trig with pong_data=8'h5A while idle -> exactly one tx_start with tx_data=8'h5A, then done.
REQ-029 The bench SHALL cover: ramp_req, read_length=2, samples 16'h1234, 16'hABCD -> bytes 07,34,12,CD,AB (+ checksum 8'h40 if the macro is defined), then done.
REQ-030 The bench SHALL cover: dc_req and pong_trig in the same cycle -> pong byte first, then the DC stream (header 08).
REQ-031 The bench SHALL cover: dc_req, read_length=0 -> header 08 only (+ checksum 00 if the macro is defined); then pong_trig during the header's WAIT -> pong sent after done.
REQ-032 The bench SHALL cover: tx_busy held high for 10 cycles after each tx_start -> no tx_start while busy, and the byte order is preserved.
REQ-033 The bench SHALL cover: rst=0 during the third byte of a ramp stream -> all outputs 0, no done; the next request runs from the header.
